sparhixcel_mem_loader: RTL and testbench
========================================

Name: sparhixcel_mem_loader

Overview:
- Host-side writer for the accelerator's input-feature and weight memories.
- Accepts a byte-serial valid/ready stream and packs N_ROWS_ARRAY lanes into one memory word.
- Issues one write strobe per packed word, at consecutive addresses starting from a programmed base.
- Drives the memory write ports directly (data, address, load strobe) for either the feature memory or the weight memory, selected per transfer.

Parameters:
- N_ROWS_ARRAY, 16, lanes per memory word (one lane per array row).
- LANE_WIDTH, 8, bits per lane; equals I_WIDTH/F_WIDTH.
- ADDR_WIDTH, 16, memory write address width.
- COUNT_WIDTH, 17, width of the word-count input (covers 0..2^ADDR_WIDTH words).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- general_rst_ni  in  1  asynchronous reset, active-low.
- start_i  in  1  one-cycle transfer request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; returns to IDLE.
- target_i  in  1  0 = feature memory, 1 = weight memory; latched at start.
- base_addr_i  in  ADDR_WIDTH  first write address; latched at start.
- num_words_i  in  COUNT_WIDTH  packed words to write; latched at start.
- s_data_i  in  LANE_WIDTH  stream byte.
- s_valid_i  in  1  stream byte valid.
- s_ready_o  out  1  loader can accept a byte.
- wr_data_o  out  N_ROWS_ARRAY*LANE_WIDTH  packed word; lane k at bits [(k+1)*LANE_WIDTH-1 : k*LANE_WIDTH].
- wr_addr_o  out  ADDR_WIDTH  write address.
- wr_feature_ld_o  out  1  write strobe, feature memory.
- wr_weight_ld_o  out  1  write strobe, weight memory.
- busy_o  out  1  transfer in progress (FILL or WRITE).
- done_o  out  1  one-cycle pulse at transfer completion.

Behaviour:
- Reset (async, general_rst_ni=0):
  - state = IDLE; all outputs 0.
  - Lane buffer, lane counter, word counter and latched config cleared.
  - Reset mid-transfer discards the partial word; no write is issued.
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - s_ready_o=0.
  - start_i=1 latches target, base and count.
  - If num_words_i=0, go to DONE; otherwise go to FILL with lane_cnt=0 and word_cnt=0.
- FILL:
  - s_ready_o=1 (combinational on state).
  - A byte is accepted on each edge where s_valid_i && s_ready_o; it is stored in lane[lane_cnt] and lane_cnt increments.
  - After the byte for lane N_ROWS_ARRAY-1 is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - s_ready_o=0.
  - wr_data_o = packed lanes; wr_addr_o = (base + word_cnt) mod 2^ADDR_WIDTH, wrapping at 0xFFFF to 0x0000.
  - Exactly one strobe is high, selected by the latched target; the other strobe stays 0.
  - Next state: DONE if word_cnt+1 == count, else FILL with word_cnt incremented and lane_cnt=0.
- DONE:
  - done_o=1 for this single cycle; busy_o=0.
  - Next state: IDLE.
- Outputs:
  - wr_data_o, wr_addr_o and the strobes are registered. Outside WRITE, strobes are 0 and data/address hold their last values.
  - busy_o=1 exactly in FILL and WRITE.
- Latency and throughput:
  - start in cycle 0 puts FILL in cycle 1.
  - The strobe is asserted in the cycle after the last lane byte is accepted.
  - Peak rate is N_ROWS_ARRAY+1 cycles per word.
  - done_o follows the final strobe by 1 cycle.
- Backpressure and stalls: s_valid_i low in FILL stalls indefinitely with state and counters held. s_data_i is ignored when no handshake occurs.
- Simultaneous events:
  - start_i outside IDLE is ignored, with no effect on the latched config.
  - abort_i has priority over everything except reset. In any non-IDLE state it forces IDLE on the next edge, with no strobe and no done_o.
  - A byte presented in the same cycle as abort is not accepted.
  - abort_i and start_i together in IDLE: start is ignored.
- Memory contract: the target memory captures data and address on the edge where its strobe is high. No read-back or acknowledge exists.

Test Plan:
1. Reset, then start with target=0, base=0x0010, count=1; stream bytes 0x01..0x10 with s_valid_i held high. Required: a single wr_feature_ld_o pulse with wr_addr_o=0x0010 and wr_data_o=0x100F0E0D0C0B0A090807060504030201; wr_weight_ld_o stays 0; done_o pulses 1 cycle later; busy_o is high for 17 cycles.
2. target=1, base=0xFFFF, count=2, with 32 bytes streamed. Required: wr_weight_ld_o pulses twice, at addresses 0xFFFF then 0x0000; the two pulses are 17 cycles apart; wr_feature_ld_o never asserts.
3. Same as scenario 1, but s_valid_i toggles 1/0 every cycle. Required: 16 bytes are accepted in 31 cycles; the packed word is identical to scenario 1; exactly one strobe is issued.
4. Assert abort_i after 7 bytes of word 0. Required: IDLE on the next edge; no strobe; no done_o; s_ready_o=0. A subsequent start with count=1 writes a fresh word containing no stale lanes.
5. count=0 start. Required: done_o pulses in cycle 1; no strobe; s_ready_o never asserts. A second start_i pulse during FILL of a count=3 transfer is ignored: three writes occur at the original base.
6. Drive general_rst_ni low for 1 cycle during WRITE of word 1 of 3. Required: all outputs are 0 immediately (asynchronously); no further strobes; done_o is never asserted.

Source files
------------

// File: rtl/sparhixcel_mem_loader_if.sv
// Bundle of the loader's control, byte-stream and memory-write signals.
// master: host/stream side that drives requests and bytes and observes writes.
// slave: the loader itself (sparhixcel_mem_loader).
interface sparhixcel_mem_loader_if #(
    parameter int N_ROWS_ARRAY = 16,
    parameter int LANE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 17
);
    // transfer control
    logic                               start_i;
    logic                               abort_i;
    logic                               target_i;
    logic [ADDR_WIDTH-1:0]              base_addr_i;
    logic [COUNT_WIDTH-1:0]             num_words_i;
    // byte stream
    logic [LANE_WIDTH-1:0]              s_data_i;
    logic                               s_valid_i;
    logic                               s_ready_o;
    // memory write ports
    logic [N_ROWS_ARRAY*LANE_WIDTH-1:0] wr_data_o;
    logic [ADDR_WIDTH-1:0]              wr_addr_o;
    logic                               wr_feature_ld_o;
    logic                               wr_weight_ld_o;
    // status
    logic                               busy_o;
    logic                               done_o;

    modport master (
        output start_i, abort_i, target_i, base_addr_i, num_words_i, s_data_i, s_valid_i,
        input  s_ready_o, wr_data_o, wr_addr_o, wr_feature_ld_o, wr_weight_ld_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, target_i, base_addr_i, num_words_i, s_data_i, s_valid_i,
        output s_ready_o, wr_data_o, wr_addr_o, wr_feature_ld_o, wr_weight_ld_o, busy_o, done_o
    );
endinterface

// File: rtl/sparhixcel_mem_loader.sv
// Packs a byte stream into N_ROWS_ARRAY-lane words and writes them to the feature or weight memory.
// Latency: start -> FILL next cycle; strobe one cycle after last lane byte; done one cycle after final strobe.
// Backpressure: s_ready high only in FILL; s_valid low stalls with all state held; abort returns to IDLE.
// Ports: clk_i, general_rst_ni (async active-low), bus (slave modport of sparhixcel_mem_loader_if).
module sparhixcel_mem_loader #(
    parameter int N_ROWS_ARRAY = 16,
    parameter int LANE_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 17
) (
    input  logic                      clk_i,
    input  logic                      general_rst_ni,
    sparhixcel_mem_loader_if.slave    bus
);
    localparam int WORD_WIDTH = N_ROWS_ARRAY * LANE_WIDTH;
    localparam int LCW        = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
    localparam logic [LCW-1:0]         LAST_LANE = LCW'(N_ROWS_ARRAY - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [WORD_WIDTH-1:0]   lane_buf;
    logic [WORD_WIDTH-1:0]   fill_word;
    logic [LCW-1:0]          lane_cnt;
    logic [COUNT_WIDTH-1:0]  word_cnt;
    logic [COUNT_WIDTH-1:0]  word_cnt_inc;
    logic [COUNT_WIDTH-1:0]  cfg_count;
    logic [ADDR_WIDTH-1:0]   cfg_base;
    logic                    cfg_target;
    logic                    accept;
    logic                    last_lane;
    logic                    last_word;
    logic                    start_ok;

    // A byte offered in an abort cycle is deliberately not taken.
    assign accept       = (state == FILL) && bus.s_valid_i && !bus.abort_i;
    assign last_lane    = (lane_cnt == LAST_LANE);
    assign word_cnt_inc = word_cnt + CNT_ONE;
    assign last_word    = (word_cnt_inc == cfg_count);
    assign start_ok     = (state == IDLE) && bus.start_i && !bus.abort_i;

    assign bus.s_ready_o = (state == FILL);
    assign bus.busy_o    = (state == FILL) || (state == WRITE);
    assign bus.done_o    = (state == DONE);

    // Lane buffer with the incoming byte merged in, so the final byte of a word
    // can be registered straight onto wr_data_o in the same edge.
    always_comb begin
        fill_word = lane_buf;
        for (int k = 0; k < N_ROWS_ARRAY; k++) begin
            if (lane_cnt == LCW'(k)) begin
                fill_word[k*LANE_WIDTH +: LANE_WIDTH] = bus.s_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort_i) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (bus.start_i) state_nxt = (bus.num_words_i == '0) ? DONE : FILL;
                FILL:  if (accept && last_lane) state_nxt = WRITE;
                WRITE: state_nxt = last_word ? DONE : FILL;
                DONE:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge general_rst_ni) begin
        if (!general_rst_ni) begin
            lane_buf            <= '0;
            lane_cnt            <= '0;
            word_cnt            <= '0;
            cfg_count           <= '0;
            cfg_base            <= '0;
            cfg_target          <= 1'b0;
            bus.wr_data_o       <= '0;
            bus.wr_addr_o       <= '0;
            bus.wr_feature_ld_o <= 1'b0;
            bus.wr_weight_ld_o  <= 1'b0;
        end else begin
            // Strobes are single-cycle: only the edge entering WRITE raises them.
            bus.wr_feature_ld_o <= 1'b0;
            bus.wr_weight_ld_o  <= 1'b0;

            if (start_ok) begin
                cfg_target <= bus.target_i;
                cfg_base   <= bus.base_addr_i;
                cfg_count  <= bus.num_words_i;
                lane_cnt   <= '0;
                word_cnt   <= '0;
            end

            if (accept) begin
                lane_buf <= fill_word;
                if (last_lane) begin
                    lane_cnt            <= '0;
                    bus.wr_data_o       <= fill_word;
                    bus.wr_addr_o       <= cfg_base + word_cnt[ADDR_WIDTH-1:0];
                    bus.wr_feature_ld_o <= !cfg_target;
                    bus.wr_weight_ld_o  <= cfg_target;
                end else begin
                    lane_cnt <= lane_cnt + LCW'(1);
                end
            end

            if ((state == WRITE) && !bus.abort_i && !last_word) begin
                word_cnt <= word_cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_sparhixcel_mem_loader.sv
module tb_sparhixcel_mem_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sparhixcel_mem_loader_if #(.N_ROWS_ARRAY(16), .LANE_WIDTH(8), .ADDR_WIDTH(16), .COUNT_WIDTH(17)) bus ();

    sparhixcel_mem_loader #(.N_ROWS_ARRAY(16), .LANE_WIDTH(8), .ADDR_WIDTH(16), .COUNT_WIDTH(17)) dut (
        .clk_i          (clk),
        .general_rst_ni (rst_n),
        .bus            (bus)
    );

    typedef struct {
        logic        tgt;
        logic [15:0] base;
        int          count;
        bit          toggle;
        logic [7:0]  seed;
        int          abort_after;  // -1: never
        int          restart_cyc;  // 0: never
        int          rst_cyc;      // 0: never
        int          exp_writes;
        int          exp_done_cyc; // -1: no done expected
        int          exp_busy;
        int          exp_rdy;
    } vec_t;

    typedef struct {
        logic         tgt;
        logic [15:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t          exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           gcyc = 0;
    int           strobe_total = 0;
    int           last_strobe_cyc = 0;
    int           prev_strobe_cyc = 0;
    logic [127:0] last_data = '0;
    logic [15:0]  last_addr = '0;
    wr_t          mon_e;
    vec_t         tbl[8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Write-port monitor: every strobe is matched against the scoreboard.
    always @(negedge clk) begin
        gcyc++;
        if (bus.wr_feature_ld_o || bus.wr_weight_ld_o) begin
            strobe_total++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = gcyc;
            last_data = bus.wr_data_o;
            last_addr = bus.wr_addr_o;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobes", {bus.wr_feature_ld_o, bus.wr_weight_ld_o}, {!mon_e.tgt, mon_e.tgt});
                chk("wr_addr", bus.wr_addr_o, mon_e.addr);
                chk("wr_data", bus.wr_data_o, mon_e.data);
            end
        end
    end

    task automatic run(input vec_t v);
        int          idx = 0;
        int          busy_cnt = 0;
        int          rdy_cnt = 0;
        int          done_cyc = -1;
        int          str0;
        bit          aborted = 0;
        wr_t         e;
        logic [7:0]  b;
        str0 = strobe_total;
        for (int w = 0; w < v.exp_writes; w++) begin
            e.tgt  = v.tgt;
            e.addr = v.base + 16'(w);
            for (int k = 0; k < 16; k++) begin
                b = v.seed + 8'(w*16 + k);
                e.data[k*8 +: 8] = b;
            end
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start_i     = 1'b1;
        bus.target_i    = v.tgt;
        bus.base_addr_i = v.base;
        bus.num_words_i = 17'(v.count);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int cyc = 1; cyc <= v.count*40 + 20; cyc++) begin
            if (v.restart_cyc == cyc) begin
                bus.start_i     = 1'b1;
                bus.target_i    = !v.tgt;
                bus.base_addr_i = ~v.base;
                bus.num_words_i = 17'd1;
            end else begin
                bus.start_i = 1'b0;
            end
            bus.abort_i   = (v.abort_after >= 0) && !aborted && (idx == v.abort_after);
            bus.s_valid_i = (idx < v.count*16) && (!v.toggle || (cyc % 2 == 1));
            bus.s_data_i  = v.seed + 8'(idx);
            if (v.rst_cyc == cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async_outputs",
                    {bus.wr_data_o, bus.wr_addr_o, bus.wr_feature_ld_o, bus.wr_weight_ld_o,
                     bus.busy_o, bus.done_o, bus.s_ready_o}, '0);
            end
            @(negedge clk);
            if (bus.busy_o) busy_cnt++;
            if (bus.s_ready_o) rdy_cnt++;
            if (bus.done_o && done_cyc < 0) done_cyc = cyc;
            if (bus.s_valid_i && bus.s_ready_o && !bus.abort_i) idx++;
            if (bus.abort_i) aborted = 1;
            @(posedge clk); #1;
            rst_n       = 1'b1;
            bus.abort_i = 1'b0;
        end
        bus.s_valid_i = 1'b0;
        chk("done_cycle", 128'(done_cyc), 128'(v.exp_done_cyc));
        chk("busy_cycles", 128'(busy_cnt), 128'(v.exp_busy));
        chk("ready_cycles", 128'(rdy_cnt), 128'(v.exp_rdy));
        chk("strobe_count", 128'(strobe_total - str0), 128'(v.exp_writes));
        chk("queue_drained", 128'(exp_q.size()), 0);
    endtask

    initial begin
        //         tgt   base      cnt tog seed   abort rst  rst  wr done busy rdy
        tbl[0] = '{1'b0, 16'h0010, 1, 0, 8'h01, -1,   0,   0,   1, 18,  17,  16};
        tbl[1] = '{1'b1, 16'hFFFF, 2, 0, 8'h20, -1,   0,   0,   2, 35,  34,  32};
        tbl[2] = '{1'b0, 16'h0010, 1, 1, 8'h01, -1,   0,   0,   1, 33,  32,  31};
        tbl[3] = '{1'b0, 16'h0020, 1, 0, 8'h50,  7,   0,   0,   0, -1,   8,   8};
        tbl[4] = '{1'b0, 16'h0020, 1, 0, 8'h80, -1,   0,   0,   1, 18,  17,  16};
        tbl[5] = '{1'b1, 16'h0300, 0, 0, 8'h00, -1,   0,   0,   0,  1,   0,   0};
        tbl[6] = '{1'b1, 16'h0100, 3, 0, 8'h60, -1,   5,   0,   3, 52,  51,  48};
        tbl[7] = '{1'b0, 16'h0040, 3, 0, 8'h30, -1,   0,  34,   1, -1,  33,  32};

        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.target_i = 1'b0;
        bus.base_addr_i = '0; bus.num_words_i = '0;
        bus.s_data_i = '0; bus.s_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {bus.wr_data_o, bus.wr_addr_o, bus.wr_feature_ld_o, bus.wr_weight_ld_o,
             bus.busy_o, bus.done_o, bus.s_ready_o}, '0);

        for (int i = 0; i < 8; i++) begin
            run(tbl[i]);
            if (i == 0 || i == 2) begin
                chk("scn1_word_const", last_data, 128'h100F0E0D0C0B0A090807060504030201);
            end
            if (i == 1) begin
                chk("wrap_addr_last", 128'(last_addr), 128'h0000);
                chk("strobe_spacing", 128'(last_strobe_cyc - prev_strobe_cyc), 128'd17);
            end
        end

        // abort and start together in IDLE: start must be ignored
        @(posedge clk); #1;
        bus.start_i = 1'b1; bus.abort_i = 1'b1; bus.num_words_i = 17'd1;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        @(negedge clk);
        chk("abort_start_idle", {bus.busy_o, bus.s_ready_o, bus.done_o}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
